// File: rtl/xnor_result_packer_if.sv
// Handshake bundle between the XNOR result stream, the packer and its consumer.
// master = environment side, slave = packer side.
interface xnor_result_packer_if #(
   parameter int WIDTH = 8
) ();
   localparam int CW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_bit;
   logic             in_ready;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_ones;
   logic [CW-1:0]    out_len;
   logic [7:0]       frame_cnt;

   modport master (
      output in_valid, in_bit, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ones, out_len, frame_cnt
   );

   modport slave (
      input  in_valid, in_bit, flush, out_ready,
      output in_ready, out_valid, out_data, out_ones, out_len, frame_cnt
   );
endinterface

// File: rtl/xnor_result_packer.sv
// Packs the XNOR result bit stream into WIDTH-bit words with popcount,
// presented on a one-entry registered output; flush emits a partial word.
module xnor_result_packer #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   xnor_result_packer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STALL
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    fill;
   logic [CW-1:0]    ones;
   logic [WIDTH-1:0] hold_data;
   logic [CW-1:0]    hold_ones;
   logic [CW-1:0]    hold_len;

   logic [WIDTH-1:0] nxt_data;
   logic [CW-1:0]    nxt_fill;
   logic [CW-1:0]    nxt_ones;
   logic             acc;
   logic             one;
   logic             hs;
   logic             slot_free;
   logic             done;

   assign bus.in_ready = (state != STALL);
   assign acc          = bus.in_valid && bus.in_ready;
   assign one          = acc && bus.in_bit;
   assign hs           = bus.out_valid && bus.out_ready;
   assign slot_free    = !bus.out_valid || bus.out_ready;

   // The bit accepted this cycle is folded in before any flush is honoured.
   always_comb begin
      nxt_data = shreg | ({{(WIDTH-1){1'b0}}, one} << fill);
      nxt_fill = fill + CW'(acc);
      nxt_ones = ones + CW'(one);
      done     = (state != STALL) &&
                 ((nxt_fill == CW'(WIDTH)) ||
                  (bus.flush && (nxt_fill != '0)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         shreg         <= '0;
         fill          <= '0;
         ones          <= '0;
         hold_data     <= '0;
         hold_ones     <= '0;
         hold_len      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ones  <= '0;
         bus.out_len   <= '0;
         bus.frame_cnt <= '0;
      end else begin
         if (hs) bus.frame_cnt <= bus.frame_cnt + 8'd1;
         unique case (state)
            IDLE, FILL: begin
               if (done) begin
                  shreg <= '0;
                  fill  <= '0;
                  ones  <= '0;
                  if (slot_free) begin
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= nxt_data;
                     bus.out_ones  <= nxt_ones;
                     bus.out_len   <= nxt_fill;
                     state         <= IDLE;
                  end else begin
                     hold_data <= nxt_data;
                     hold_ones <= nxt_ones;
                     hold_len  <= nxt_fill;
                     state     <= STALL;
                  end
               end else begin
                  shreg <= nxt_data;
                  fill  <= nxt_fill;
                  ones  <= nxt_ones;
                  state <= (nxt_fill != '0) ? FILL : IDLE;
                  if (hs) bus.out_valid <= 1'b0;
               end
            end
            // out_valid is necessarily 1 here, so the swap keeps it high.
            STALL: begin
               if (bus.out_ready) begin
                  bus.out_data <= hold_data;
                  bus.out_ones <= hold_ones;
                  bus.out_len  <= hold_len;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xnor_result_packer.sv
// Randomized and directed bench for xnor_result_packer against a
// queue-based word model.
module tb_xnor_result_packer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xnor_result_packer_if #(.WIDTH(W)) bus ();

   xnor_result_packer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   bit cur[$];
   bit m_ov, m_hv;
   int m_data, m_ones, m_len, m_fc;
   int h_data, h_ones, h_len;

   task automatic chk(string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: a word is the list of accepted bits; slot and held word are
   // tracked as plain values.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur.delete();
         m_ov = 0; m_hv = 0; m_fc = 0;
         m_data = 0; m_ones = 0; m_len = 0;
      end else begin
         bit hs;
         int w, o;
         hs = m_ov && bus.out_ready;
         if (m_hv) begin
            if (bus.out_ready) begin
               m_data = h_data; m_ones = h_ones; m_len = h_len;
               m_hv = 0;
            end
         end else begin
            if (bus.in_valid) cur.push_back(bus.in_bit);
            if (cur.size() == W || (bus.flush && cur.size() > 0)) begin
               w = 0; o = 0;
               foreach (cur[i]) begin
                  w += int'(cur[i]) << i;
                  o += int'(cur[i]);
               end
               if (!m_ov || bus.out_ready) begin
                  m_data = w; m_ones = o; m_len = cur.size(); m_ov = 1;
               end else begin
                  h_data = w; h_ones = o; h_len = cur.size(); m_hv = 1;
               end
               cur.delete();
            end else if (hs) begin
               m_ov = 0;
            end
         end
         if (hs) m_fc = (m_fc + 1) % 256;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", bus.in_ready, !m_hv);
         chk("out_valid", bus.out_valid, m_ov);
         chk("frame_cnt", bus.frame_cnt, m_fc);
         if (m_ov) begin
            chk("out_data", bus.out_data, m_data);
            chk("out_ones", bus.out_ones, m_ones);
            chk("out_len", bus.out_len, m_len);
         end
      end
   end

   task automatic drive_bit(input bit b, input bit fl = 1'b0);
      bus.in_valid = 1'b1;
      bus.in_bit = b;
      bus.flush = fl;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < W; i++) drive_bit(w[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit fl;
      bus.in_valid = 1'b0;
      bus.in_bit = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst frame_cnt", bus.frame_cnt, 0);
      chk("rst in_ready", bus.in_ready, 1);
      chk("rst out_data", bus.out_data, 0);
      chk("rst out_len", bus.out_len, 0);

      // XNOR truth table 1,0,0,1,0,1,1,0
      send_word(8'h69);
      chk("tt valid", bus.out_valid, 1);
      chk("tt data", bus.out_data, 8'h69);
      chk("tt ones", bus.out_ones, 4);
      chk("tt len", bus.out_len, 8);
      idle(1);
      chk("tt frame_cnt", bus.frame_cnt, 1);

      // partial flush
      drive_bit(1); drive_bit(1); drive_bit(1);
      bus.flush = 1'b1;
      idle(1);
      bus.flush = 1'b0;
      chk("fl data", bus.out_data, 8'h07);
      chk("fl ones", bus.out_ones, 3);
      chk("fl len", bus.out_len, 3);
      idle(1);

      // back-pressure
      do_reset();
      bus.out_ready = 1'b0;
      send_word(8'hFF);
      send_word(8'h00);
      chk("bp in_ready", bus.in_ready, 0);
      chk("bp data held", bus.out_data, 8'hFF);
      idle(2);
      chk("bp data stable", bus.out_data, 8'hFF);
      bus.out_ready = 1'b1;
      idle(1);
      bus.out_ready = 1'b0;
      chk("bp swap data", bus.out_data, 8'h00);
      chk("bp swap ones", bus.out_ones, 0);
      chk("bp swap valid", bus.out_valid, 1);
      chk("bp swap cnt", bus.frame_cnt, 1);
      chk("bp ready back", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      idle(1);
      chk("bp drain cnt", bus.frame_cnt, 2);
      chk("bp drain valid", bus.out_valid, 0);

      // flush in IDLE, flush with 8th bit
      do_reset();
      bus.flush = 1'b1;
      idle(1);
      bus.flush = 1'b0;
      chk("idle fl valid", bus.out_valid, 0);
      chk("idle fl cnt", bus.frame_cnt, 0);
      for (int i = 0; i < 7; i++) drive_bit(1);
      drive_bit(0, 1);
      chk("fl8 len", bus.out_len, 8);
      chk("fl8 data", bus.out_data, 8'h7F);
      idle(1);
      chk("fl8 single", bus.out_valid, 0);
      chk("fl8 cnt", bus.frame_cnt, 1);

      // frame_cnt wrap
      do_reset();
      repeat (256) send_word(8'($urandom));
      chk("wrap pre", bus.frame_cnt, 255);
      idle(1);
      chk("wrap zero", bus.frame_cnt, 0);
      send_word(8'hA5);
      idle(1);
      chk("wrap one", bus.frame_cnt, 1);

      // reset mid-word
      send_word(8'h3C);
      idle(1);
      for (int i = 0; i < 5; i++) drive_bit(1);
      rst_n = 1'b0;
      #1;
      chk("rstw valid", bus.out_valid, 0);
      chk("rstw cnt", bus.frame_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_word(8'h5A);
      chk("rstw data", bus.out_data, 8'h5A);
      chk("rstw ones", bus.out_ones, 4);
      chk("rstw len", bus.out_len, 8);
      idle(1);

      // reset during STALL
      bus.out_ready = 1'b0;
      send_word(8'hFF);
      send_word(8'h0F);
      chk("rsts stall", bus.in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("rsts valid", bus.out_valid, 0);
      chk("rsts cnt", bus.frame_cnt, 0);
      chk("rsts ready", bus.in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      send_word(8'hC3);
      chk("rsts data", bus.out_data, 8'hC3);
      chk("rsts ones", bus.out_ones, 4);
      chk("rsts len", bus.out_len, 8);
      idle(1);

      // random traffic
      do_reset();
      repeat (3000) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_bit = 1'($urandom);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 15) == 0);
         if (cur.size() == 0 && bus.in_valid) fl = 1'b0;
         bus.flush = fl;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
